// File: rtl/stopwatch_pkg.sv
// Shared types and BCD helpers for the stopwatch block: FSM state enum, digit limits,
// and single-step BCD increment/decrement over an MM:SS value.
package stopwatch_pkg;

    localparam int unsigned BCD_W = 4;
    localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;
    localparam logic [BCD_W-1:0] DIGIT_MAX = 4'd9;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPause,
        StDone
    } sw_state_e;

    typedef struct packed {
        logic [BCD_W-1:0] min_tens;
        logic [BCD_W-1:0] min_ones;
        logic [BCD_W-1:0] sec_tens;
        logic [BCD_W-1:0] sec_ones;
    } bcd_time_t;

    // One second forward with carries; the caller handles the MAX_MIN:59 wrap.
    function automatic bcd_time_t bcd_inc(input bcd_time_t t);
        bcd_time_t n;
        n = t;
        if (t.sec_ones != DIGIT_MAX) begin
            n.sec_ones = t.sec_ones + 4'd1;
        end else begin
            n.sec_ones = '0;
            if (t.sec_tens != SEC_TENS_MAX) begin
                n.sec_tens = t.sec_tens + 4'd1;
            end else begin
                n.sec_tens = '0;
                if (t.min_ones != DIGIT_MAX) begin
                    n.min_ones = t.min_ones + 4'd1;
                end else begin
                    n.min_ones = '0;
                    n.min_tens = t.min_tens + 4'd1;
                end
            end
        end
        return n;
    endfunction

    // One second backward with borrows; 00:00 rolls under to max_t.
    function automatic bcd_time_t bcd_dec(input bcd_time_t t, input bcd_time_t max_t);
        bcd_time_t n;
        n = t;
        if (t == '0) begin
            n = max_t;
        end else if (t.sec_ones != '0) begin
            n.sec_ones = t.sec_ones - 4'd1;
        end else begin
            n.sec_ones = DIGIT_MAX;
            if (t.sec_tens != '0) begin
                n.sec_tens = t.sec_tens - 4'd1;
            end else begin
                n.sec_tens = SEC_TENS_MAX;
                if (t.min_ones != '0) begin
                    n.min_ones = t.min_ones - 4'd1;
                end else begin
                    n.min_ones = DIGIT_MAX;
                    n.min_tens = t.min_tens - 4'd1;
                end
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchronizer for a raw push button followed by a rising-edge detector that
// yields a single one-cycle press pulse however long the button is held.
module btn_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= btn;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign press = sync_q & ~prev_q;

endmodule

// File: rtl/bcd_stopwatch.sv
// BCD MM:SS stopwatch counting rising edges of a data-sampled slow clock.
// Define STOPWATCH_COUNTDOWN_EN to add the count_down port, preset load and the DONE state.
module bcd_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int unsigned EDGES_PER_SEC = 1,
    parameter int unsigned MAX_MIN       = 59,
    parameter int unsigned PRESET_MIN    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             slow_clk,
    input  logic             start_btn,
    input  logic             clear_btn,
`ifdef STOPWATCH_COUNTDOWN_EN
    input  logic             count_down,
`endif
    output logic [BCD_W-1:0] sec_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] min_tens,
    output logic             running,
    output logic             wrap,
    output logic             done
);

    localparam int unsigned PRE_W = (EDGES_PER_SEC > 1) ? $clog2(EDGES_PER_SEC) : 1;
    localparam logic [PRE_W-1:0] PRESC_LAST = PRE_W'(EDGES_PER_SEC - 1);
    localparam bcd_time_t MAX_TIME = {BCD_W'(MAX_MIN / 10), BCD_W'(MAX_MIN % 10),
                                      SEC_TENS_MAX, DIGIT_MAX};
    localparam bcd_time_t PRESET_TIME = {BCD_W'(PRESET_MIN / 10), BCD_W'(PRESET_MIN % 10),
                                         {BCD_W{1'b0}}, {BCD_W{1'b0}}};

    logic             slow_q;
    logic             slow_edge;
    logic             start_press;
    logic             clear_press;
    logic             cd;
    logic             advance;
    logic             sec_tick;
    sw_state_e        state_q, state_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    bcd_time_t        time_q, time_d;
    bcd_time_t        step_time;
    logic             wrap_q, wrap_d;
    logic             running_q;

`ifdef STOPWATCH_COUNTDOWN_EN
    assign cd = count_down;
`else
    assign cd = 1'b0;
`endif

    btn_edge_sync u_start_sync (
        .clk   (clk),
        .reset (reset),
        .btn   (start_btn),
        .press (start_press)
    );

    btn_edge_sync u_clear_sync (
        .clk   (clk),
        .reset (reset),
        .btn   (clear_btn),
        .press (clear_press)
    );

    assign slow_edge = slow_clk & ~slow_q;

    // Higher-priority button actions swallow any slow edge landing on the same cycle.
    assign advance  = slow_edge && (state_q == StRun) && !clear_press && !start_press;
    assign sec_tick = advance && (presc_q == PRESC_LAST);

    always_comb begin
        state_d   = state_q;
        time_d    = time_q;
        presc_d   = presc_q;
        wrap_d    = 1'b0;
        step_time = cd ? bcd_dec(time_q, MAX_TIME) : bcd_inc(time_q);

        if (clear_press) begin
            state_d = StIdle;
            time_d  = cd ? PRESET_TIME : '0;
            presc_d = '0;
        end else if (start_press) begin
            unique case (state_q)
                StIdle:  state_d = StRun;
                StRun:   state_d = StPause;
                StPause: state_d = StRun;
                StDone:  state_d = StDone;
            endcase
        end else if (advance) begin
            presc_d = sec_tick ? '0 : presc_q + 1'b1;
            if (sec_tick) begin
                if (cd) begin
                    time_d = step_time;
                    if (step_time == '0) begin
                        state_d = StDone;
                    end
                end else if (time_q == MAX_TIME) begin
                    time_d = '0;
                    wrap_d = 1'b1;
                end else begin
                    time_d = step_time;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slow_q    <= 1'b0;
            presc_q   <= '0;
            state_q   <= StIdle;
            time_q    <= '0;
            wrap_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            slow_q    <= slow_clk;
            presc_q   <= presc_d;
            state_q   <= state_d;
            time_q    <= time_d;
            wrap_q    <= wrap_d;
            running_q <= (state_d == StRun);
        end
    end

`ifdef STOPWATCH_COUNTDOWN_EN
    logic done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (state_d == StDone);
        end
    end

    assign done = done_q;
`else
    assign done = 1'b0;
`endif

    assign sec_ones = time_q.sec_ones;
    assign sec_tens = time_q.sec_tens;
    assign min_ones = time_q.min_ones;
    assign min_tens = time_q.min_tens;
    assign running  = running_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Self-checking bench for bcd_stopwatch: table vectors, directed corner sequences and
// random stimulus against a seconds-counter reference model.
module tb_bcd_stopwatch;

    localparam int unsigned EPS    = 1;
    localparam int unsigned MAXM   = 59;
    localparam int unsigned PRESET = 1;
    localparam int TOTAL = (MAXM + 1) * 60;

    localparam int MIdle  = 0;
    localparam int MRun   = 1;
    localparam int MPause = 2;
    localparam int MDone  = 3;

    logic clk = 1'b0;
    logic reset, slow_clk, start_btn, clear_btn, count_down;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic running, wrap, done;

    int checks = 0;
    int errors = 0;

    // Reference model state: elapsed seconds as a plain integer.
    int m_secs, m_state, m_presc;
    bit m_wrap, m_slow_prev;
    bit sh[3];
    bit ch[3];

    typedef struct {
        logic        start;
        logic        clear;
        logic        slow;
        logic [18:0] exp;
    } vec_t;

    vec_t tbl[12];

    bcd_stopwatch #(
        .EDGES_PER_SEC (EPS),
        .MAX_MIN       (MAXM),
        .PRESET_MIN    (PRESET)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .slow_clk   (slow_clk),
        .start_btn  (start_btn),
        .clear_btn  (clear_btn),
`ifdef STOPWATCH_COUNTDOWN_EN
        .count_down (count_down),
`endif
        .sec_ones   (sec_ones),
        .sec_tens   (sec_tens),
        .min_ones   (min_ones),
        .min_tens   (min_tens),
        .running    (running),
        .wrap       (wrap),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] mk(input int s, input bit r, input bit w, input bit d);
        int mm;
        int ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), r, w, d};
    endfunction

    function automatic logic [18:0] dut_vec();
        return {min_tens, min_ones, sec_tens, sec_ones, running, wrap, done};
    endfunction

    function automatic logic [18:0] model_vec();
        return mk(m_secs, m_state == MRun, m_wrap, m_state == MDone);
    endfunction

    function automatic bit cd_eff();
`ifdef STOPWATCH_COUNTDOWN_EN
        return count_down;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [18:0] got, input logic [18:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s got=%h expected=%h (mt,mo,st,so,run,wrap,done)", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_secs = 0; m_state = MIdle; m_presc = 0; m_wrap = 0; m_slow_prev = 0;
        for (int i = 0; i < 3; i++) begin
            sh[i] = 0;
            ch[i] = 0;
        end
    endtask

    // Advance the model across one clk edge using the inputs currently applied.
    task automatic model_step();
        bit sp, cp, edge_s;
        sp = sh[1] & ~sh[2];
        cp = ch[1] & ~ch[2];
        edge_s = slow_clk & ~m_slow_prev;
        m_slow_prev = slow_clk;
        sh[2] = sh[1]; sh[1] = sh[0]; sh[0] = start_btn;
        ch[2] = ch[1]; ch[1] = ch[0]; ch[0] = clear_btn;
        m_wrap = 0;
        if (cp) begin
            m_state = MIdle;
            m_secs  = cd_eff() ? PRESET * 60 : 0;
            m_presc = 0;
        end else if (sp) begin
            case (m_state)
                MIdle:   m_state = MRun;
                MRun:    m_state = MPause;
                MPause:  m_state = MRun;
                default: ;
            endcase
        end else if (edge_s && m_state == MRun) begin
            if (m_presc == EPS - 1) begin
                m_presc = 0;
                if (cd_eff()) begin
                    m_secs = (m_secs == 0) ? TOTAL - 1 : m_secs - 1;
                    if (m_secs == 0) m_state = MDone;
                end else if (m_secs == TOTAL - 1) begin
                    m_secs = 0;
                    m_wrap = 1;
                end else begin
                    m_secs++;
                end
            end else begin
                m_presc++;
            end
        end
    endtask

    task automatic cycle(input string name);
        model_step();
        @(posedge clk);
        #1;
        check(name, dut_vec(), model_vec());
    endtask

    // Asserted mid-cycle so the asynchronous path is exercised.
    task automatic do_reset();
        start_btn = 0; clear_btn = 0; slow_clk = 0;
        #2 reset = 1;
        model_reset();
        #1 check("reset_async", dut_vec(), 19'h0);
        @(posedge clk);
        #1 check("reset_held", dut_vec(), 19'h0);
        reset = 0;
    endtask

    task automatic edges(input int n);
        for (int i = 0; i < n; i++) begin
            slow_clk = 0;
            cycle("edge_lo");
            slow_clk = 1;
            cycle("edge_hi");
        end
    endtask

    task automatic press(input bit is_start);
        if (is_start) start_btn = 1; else clear_btn = 1;
        cycle("press_hi");
        start_btn = 0;
        clear_btn = 0;
        cycle("press_lo");
        cycle("press_act");
    endtask

    initial begin
        reset = 0; slow_clk = 0; start_btn = 0; clear_btn = 0; count_down = 0;

        tbl[0]  = '{1, 0, 0, mk(0, 0, 0, 0)};
        tbl[1]  = '{1, 0, 0, mk(0, 0, 0, 0)};
        tbl[2]  = '{0, 0, 0, mk(0, 1, 0, 0)};
        tbl[3]  = '{0, 0, 1, mk(1, 1, 0, 0)};
        tbl[4]  = '{0, 0, 1, mk(1, 1, 0, 0)};
        tbl[5]  = '{0, 0, 0, mk(1, 1, 0, 0)};
        tbl[6]  = '{0, 0, 1, mk(2, 1, 0, 0)};
        tbl[7]  = '{0, 0, 0, mk(2, 1, 0, 0)};
        tbl[8]  = '{0, 1, 0, mk(2, 1, 0, 0)};
        tbl[9]  = '{0, 1, 0, mk(2, 1, 0, 0)};
        tbl[10] = '{0, 0, 0, mk(0, 0, 0, 0)};
        tbl[11] = '{0, 0, 1, mk(0, 0, 0, 0)};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            start_btn = tbl[i].start;
            clear_btn = tbl[i].clear;
            slow_clk  = tbl[i].slow;
            model_step();
            @(posedge clk);
            #1 check($sformatf("table_%0d", i), dut_vec(), tbl[i].exp);
        end

        // Reset in the middle of a run.
        press(1);
        edges(37);
        check("run_0037", dut_vec(), mk(37, 1, 0, 0));
        do_reset();

        // 61 edges then on to the MAX:59 wrap.
        press(1);
        edges(61);
        check("run_0101", dut_vec(), mk(61, 1, 0, 0));
        edges(TOTAL - 2 - 61);
        check("run_5958", dut_vec(), mk(TOTAL - 2, 1, 0, 0));
        edges(1);
        check("run_5959", dut_vec(), mk(TOTAL - 1, 1, 0, 0));
        slow_clk = 0;
        cycle("wrap_pre");
        slow_clk = 1;
        cycle("wrap_edge");
        check("wrap_pulse", dut_vec(), mk(0, 1, 1, 0));
        slow_clk = 0;
        cycle("wrap_post");
        check("wrap_clear", dut_vec(), mk(0, 1, 0, 0));

        // Start and clear land on the same cycle as a slow edge.
        do_reset();
        press(1);
        edges(10);
        check("run_0010", dut_vec(), mk(10, 1, 0, 0));
        start_btn = 1; clear_btn = 1; slow_clk = 0;
        cycle("coinc_a");
        start_btn = 0; clear_btn = 0;
        cycle("coinc_b");
        slow_clk = 1;
        cycle("coinc_c");
        check("coinc_cleared", dut_vec(), mk(0, 0, 0, 0));
        slow_clk = 0;
        cycle("coinc_d");
        check("coinc_idle", dut_vec(), mk(0, 0, 0, 0));

        // Pause/resume, then a long button hold.
        press(1);
        edges(5);
        press(1);
        check("paused_0005", dut_vec(), mk(5, 0, 0, 0));
        edges(10);
        check("paused_hold", dut_vec(), mk(5, 0, 0, 0));
        press(1);
        edges(3);
        check("resumed_0008", dut_vec(), mk(8, 1, 0, 0));
        start_btn = 1;
        for (int i = 0; i < 100; i++) cycle("btn_held");
        start_btn = 0;
        cycle("btn_release");
        check("single_toggle", dut_vec(), mk(8, 0, 0, 0));

`ifdef STOPWATCH_COUNTDOWN_EN
        do_reset();
        count_down = 1;
        press(0);
        check("cd_preset", dut_vec(), mk(60, 0, 0, 0));
        press(1);
        edges(60);
        check("cd_done", dut_vec(), mk(0, 0, 0, 1));
        press(1);
        check("cd_start_ignored", dut_vec(), mk(0, 0, 0, 1));
        press(0);
        check("cd_reload", dut_vec(), mk(60, 0, 0, 0));
        count_down = 0;
`endif

        // Random buttons and slow-clock activity against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            start_btn = ($urandom_range(0, 40) == 0);
            clear_btn = ($urandom_range(0, 150) == 0);
            if ($urandom_range(0, 2) == 0) slow_clk = ~slow_clk;
`ifdef STOPWATCH_COUNTDOWN_EN
            if ($urandom_range(0, 200) == 0) count_down = ~count_down;
`endif
            cycle("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
